dmem_port_arbiter: RTL

Shares the single-ported data memory between the pipeline's M stage and the display/debug read requester that feeds the seven-segment scanner. CPU accesses normally win and complete in the same cycle. A debug read waits for an idle M-stage cycle, or after a bounded starvation interval takes one cycle and stalls the pipeline. The block sits between M-stage control (MemRead/MemWrite, ALU address, store data) and the data memory, and replaces the separate debug read port.

---
 rtl/dmem_port_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares the data memory between the M stage and the debug read requester
module dmem_port_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_valid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic          pend;
    logic [AW-1:0] pend_addr;
    logic [7:0]    starve_cnt;
    logic          dbg_force;
    logic          dbg_grant;
    logic          dbg_accept;

    // Arbitration and memory mux: the CPU owns the port unless the debug read is pending
    // on an idle M-stage cycle or has been starved long enough to be forced.
    always_comb begin
        dbg_force  = pend && (starve_cnt == STARVE_LIM);
        dbg_grant  = pend && (!cpu_req || dbg_force);
        dbg_accept = dbg_req && !pend && !dbg_valid;
        cpu_stall  = cpu_req && dbg_force;
        cpu_rdata  = mem_rdata;
        mem_wdata  = cpu_wdata;
        if (dbg_grant) begin
            mem_addr = pend_addr;
            mem_we   = 1'b0;
        end else begin
            mem_addr = cpu_addr;
            mem_we   = cpu_req && cpu_we;
        end
    end

    // Pending debug request: captured when idle, released on the service edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= 1'b0;
            pend_addr <= '0;
        end else if (dbg_grant) begin
            pend <= 1'b0;
        end else if (dbg_accept) begin
            pend      <= 1'b1;
            pend_addr <= dbg_addr;
        end
    end

    // Starvation counter: counts CPU-won cycles while a request waits, stops at the force point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!pend || dbg_grant) begin
            starve_cnt <= '0;
        end else if (cpu_req && !dbg_force) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    // Debug response: capture read data on the service edge and pulse valid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_rdata <= '0;
            dbg_valid <= 1'b0;
        end else begin
            dbg_valid <= dbg_grant;
            if (dbg_grant) begin
                dbg_rdata <= mem_rdata;
            end
        end
    end

endmodule
